// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multicycle restoring divider for the CPU's DIV instruction. The control
//   unit pulses (or holds) start with the A/B register values on dividend
//   and divisor. One quotient bit is produced per clock. The quotient and
//   remainder are written to lo/hi together with a one-cycle done pulse.
//   A zero divisor skips the iteration and raises div_zero with done. In
//   that case hi/lo keep their previous values.
//
//   Arithmetic is MIPS DIV: truncation toward zero, and the remainder takes
//   the sign of the dividend.
//
// Parameters
//   WIDTH        operand / quotient / remainder width (iterations = WIDTH)
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high; aborts any operation in flight
//   start        request, only looked at while idle
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   is_unsigned  (only with SEQ_DIV_UNSIGNED_EN) 1 = DIVU, sampled with start
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle completion pulse
//   div_zero     one-cycle pulse alongside done when the divisor was zero
//   hi           remainder, held until the next successful completion
//   lo           quotient, held until the next successful completion
//
// Configuration
//   SEQ_DIV_UNSIGNED_EN  when defined, adds is_unsigned and DIVU support.
//                        When undefined, every division is signed.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // PREP sits between the capture and the iteration. The captured divisor
  // is tested for zero there, and both operands are converted to
  // magnitudes there.
  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE,
    ZERO
  } state_t;

  state_t state, state_next;

  // q starts as the dividend, then shifts out dividend bits as it shifts in
  // quotient bits. dabs starts as the raw divisor, then becomes |divisor|.
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dabs;
  logic [CNT_W-1:0] count;
  logic             unsigned_r;
  logic             neg_q;
  logic             neg_r;

  logic             unsigned_sel;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   rem_trial;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign unsigned_sel = is_unsigned;
`else
  assign unsigned_sel = 1'b0;
`endif

  // Signs are taken from the raw operands while they still sit in q/dabs
  // during PREP. They are ignored entirely for DIVU.
  assign sign_a = q[WIDTH-1]    & ~unsigned_r;
  assign sign_b = dabs[WIDTH-1] & ~unsigned_r;

  // One restoring step. The trial remainder is one bit wider than WIDTH.
  // This keeps the shifted-out MSB, which can be set for unsigned divisors
  // at or above 2**(WIDTH-1). No borrow means the divisor fits and the
  // quotient bit is 1.
  assign rem_trial = {rem, q[WIDTH-1]};
  assign rem_diff  = rem_trial - {1'b0, dabs};
  assign take      = ~rem_diff[WIDTH];
  assign rem_next  = take ? rem_diff[WIDTH-1:0] : rem_trial[WIDTH-1:0];
  assign q_next    = {q[WIDTH-2:0], take};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    div_zero   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = PREP;
        end
      end
      PREP: begin
        state_next = (dabs == '0) ? ZERO : CALC;
      end
      CALC: begin
        if (count == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ZERO: begin
        done       = 1'b1;
        div_zero   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // In the most-negative case, the two's-complement negations wrap to the
  // same bit pattern. Because the magnitudes are treated as unsigned,
  // 0x80..0 / -1 falls out naturally as lo = 0x80..0, hi = 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      q          <= '0;
      rem        <= '0;
      dabs       <= '0;
      count      <= '0;
      unsigned_r <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q          <= dividend;
            dabs       <= divisor;
            unsigned_r <= unsigned_sel;
          end
        end
        PREP: begin
          neg_q <= sign_a ^ sign_b;
          neg_r <= sign_a;
          q     <= sign_a ? -q : q;
          dabs  <= sign_b ? -dabs : dabs;
          rem   <= '0;
          count <= CNT_W'(WIDTH - 1);
        end
        CALC: begin
          rem   <= rem_next;
          q     <= q_next;
          count <= count - CNT_W'(1);
        end
        FIX: begin
          lo <= neg_q ? -q : q;
          hi <= neg_r ? -rem : rem;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH = 32).
//
//   A cycle-level reference model runs on every rising edge. It predicts
//   busy/done/div_zero/hi/lo from plain 64-bit arithmetic and the
//   start-to-done timing. A compare process checks the DUT against the
//   model on every falling edge. Directed vectors also carry hand-computed
//   quotient, remainder and latency values.
//
//   Define SEQ_DIV_UNSIGNED_EN to also exercise the DIVU port.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_uns;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIV_UNSIGNED_EN
    .is_unsigned (is_uns),
`endif
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model. For the cycle following rising edge e, it predicts
  // whether an operation is in flight, whether this is its completion
  // cycle, and the values hi/lo must hold.
  int           edge_cnt    = 0;
  bit           m_valid     = 0;
  bit           m_pending   = 0;
  bit           m_zero      = 0;
  int           m_done_edge = 0;
  int           m_free_edge = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic         e_busy = 0, e_done = 0, e_dz = 0;

  always @(posedge clock) begin
    longint       sa, sb;
    logic [63:0]  qv, rv;
    bit           uns;
    edge_cnt++;
`ifdef SEQ_DIV_UNSIGNED_EN
    uns = is_uns;
`else
    uns = 1'b0;
`endif
    if (reset) begin
      m_valid     = 1;
      m_pending   = 0;
      m_free_edge = edge_cnt + 1;
      m_hi        = '0;
      m_lo        = '0;
    end else begin
      if (edge_cnt >= m_free_edge && start) begin
        m_pending   = 1;
        m_zero      = (divisor == '0);
        m_done_edge = edge_cnt + (m_zero ? 1 : W + 2);
        m_free_edge = m_done_edge + 2;
        if (!m_zero) begin
          if (uns) begin
            sa = longint'({32'b0, dividend});
            sb = longint'({32'b0, divisor});
          end else begin
            sa = longint'($signed(dividend));
            sb = longint'($signed(divisor));
          end
          qv   = sa / sb;
          rv   = sa % sb;
          r_lo = qv[31:0];
          r_hi = rv[31:0];
        end
      end
      if (m_pending && !m_zero && edge_cnt == m_done_edge) begin
        m_hi = r_hi;
        m_lo = r_lo;
      end
    end
    e_busy = m_pending && (edge_cnt <= m_done_edge);
    e_done = m_pending && (edge_cnt == m_done_edge);
    e_dz   = e_done && m_zero;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      checkOutput("cyc_busy", {31'b0, busy}, {31'b0, e_busy});
      checkOutput("cyc_done", {31'b0, done}, {31'b0, e_done});
      checkOutput("cyc_div_zero", {31'b0, div_zero}, {31'b0, e_dz});
      checkOutput("cyc_hi", hi, m_hi);
      checkOutput("cyc_lo", lo, m_lo);
    end
  end

  // Drives one start pulse. On return, we are at the falling edge just
  // after the rising edge that sampled start.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic u);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    is_uns   = u;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic waitDone(output int k);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         u;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int k, n, pulses;
    $display("[TB] seq_divider bench starting");
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_uns = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_div_zero", {31'b0, div_zero}, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    reset = 1'b0;

    vecs.push_back('{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 34});
    vecs.push_back('{32'd5,        32'd0,        1'b0, 32'd14,       32'd2,        1'b1, 1});
    vecs.push_back('{32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0,        1'b0, 34});
    vecs.push_back('{32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 32'd3,        32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd0,        32'hFFFFFFFF, 1'b0, 34});
    vecs.push_back('{32'h80000000, 32'd2,        1'b0, 32'hC0000000, 32'd0,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,        32'hFFFFFFFF, 1'b0, 34});
`ifdef SEQ_DIV_UNSIGNED_EN
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        1'b1, 32'h7FFFFFFF, 32'd1,        1'b0, 34});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 32'd1,        32'd1,        1'b0, 34});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 1'b0, 34});
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].u);
      waitDone(k);
      checkOutput($sformatf("v%0d_latency", i), k, vecs[i].lat);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      checkOutput($sformatf("v%0d_div_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
      checkOutput($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd1);
      @(negedge clock);
      checkOutput($sformatf("v%0d_busy_after", i), {31'b0, busy}, 32'd0);
    end

    // Reset during the 10th CALC cycle aborts the operation without a done.
    applyStimulus(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    pulses = 0;
    repeat (50) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
    end
    checkOutput("abort_no_done", pulses, 32'd0);

    // A start raised while busy is ignored, so exactly one done results.
    applyStimulus(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
    end
    checkOutput("midcalc_one_done", pulses, 32'd1);
    checkOutput("midcalc_lo", lo, 32'd14);

    // A held start re-triggers in the idle cycle right after done.
    @(negedge clock);
    dividend = 32'd9; divisor = 32'd3; is_uns = 1'b0; start = 1'b1;
    @(negedge clock);
    waitDone(k);
    checkOutput("held_first_latency", k, 32'd34);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 100);
    start = 1'b0;
    checkOutput("held_retrigger_gap", n, 32'd36);
    checkOutput("held_lo", lo, 32'd3);
    checkOutput("held_hi", hi, 32'd0);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
